// File: rtl/fphub_div_pkg.sv
// Shared types for the FPHUB divider issue stage: word type, sequencer states
// and the operand-pair layout carried through the operand FIFO.
package fphub_div_pkg;

    localparam int FPHUB_M = 23;
    localparam int FPHUB_E = 8;
    localparam int T       = FPHUB_M + FPHUB_E;

    typedef logic [T:0] fphub_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    typedef struct packed {
        fphub_word_t x;
        fphub_word_t d;
    } op_pair_t;

    // Saturated signed-infinity pattern returned when the divider never answers.
    function automatic fphub_word_t sat_inf(input logic sign);
        return {sign, {T{1'b1}}};
    endfunction

endpackage

// File: rtl/fphub_op_fifo.sv
// Operand FIFO: synchronous, power-of-two depth, registered occupancy count.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module fphub_op_fifo
    import fphub_div_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [W-1:0]              i_wdata,
    input  logic                      i_pop,
    output logic [W-1:0]              o_rdata,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count holds on simultaneous push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fphub_div_sequencer.sv
// Issue stage for the FPHUB SRT divider. Buffers operand pairs, issues one
// division at a time with a single-cycle start pulse, holds operands until the
// divider finishes and presents the result through a one-entry output register.
// Optional build macro: FPHUB_DIV_TIMEOUT_EN adds a WAIT-state watchdog that
// returns a saturated infinity and pulses timeout_err.
module fphub_div_sequencer
    import fphub_div_pkg::*;
#(
    parameter int M       = 23,
    parameter int E       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M+E:0]           in_x,
    input  logic [M+E:0]           in_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M+E:0]           out_res,
    output logic                   div_start,
    output logic [M+E:0]           div_x,
    output logic [M+E:0]           div_d,
    input  logic [M+E:0]           div_res,
    input  logic                   div_finish,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
`ifdef FPHUB_DIV_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);
    localparam int W = M + E + 1;

    seq_state_t                r_state;
    seq_state_t                w_next_state;
    logic                      w_pop;
    logic                      w_capture;
    logic                      w_timeout;
    logic                      w_wd_expired;
    logic                      w_push;
    logic [2*W-1:0]            w_fifo_rdata;
    logic [$clog2(DEPTH):0]    w_fifo_count;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      r_div_start;
    logic [W-1:0]              r_div_x;
    logic [W-1:0]              r_div_d;
    logic [W-1:0]              r_out_res;
    logic                      r_out_valid;

    assign w_push = in_valid && in_ready;

    fphub_op_fifo #(
        .W     (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({in_x, in_d}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef FPHUB_DIV_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] r_wd_cnt;
    logic           r_timeout_err;

    assign w_wd_expired = (r_wd_cnt == WDW'(TIMEOUT - 1));
    assign timeout_err  = r_timeout_err;

    // Watchdog: counts cycles spent in WAIT, cleared in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt      <= {WDW{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == WAIT) begin
                r_wd_cnt <= r_wd_cnt + WDW'(1);
            end else begin
                r_wd_cnt <= {WDW{1'b0}};
            end
        end
    end
`else
    assign w_wd_expired = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a finish seen during ISSUE is stale and ignored.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty && !r_out_valid) begin
                    w_next_state = ISSUE;
                    w_pop        = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (div_finish) begin
                    w_capture    = 1'b1;
                    w_next_state = IDLE;
                end else if (w_wd_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand latch, start pulse and one-entry result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_start <= 1'b0;
            r_div_x     <= {W{1'b0}};
            r_div_d     <= {W{1'b0}};
            r_out_res   <= {W{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            r_div_start <= w_pop;
            if (w_pop) begin
                r_div_x <= w_fifo_rdata[2*W-1:W];
                r_div_d <= w_fifo_rdata[W-1:0];
            end
            if (w_capture) begin
                r_out_res   <= div_res;
                r_out_valid <= 1'b1;
            end else if (w_timeout) begin
                r_out_res   <= {r_div_x[M+E] ^ r_div_d[M+E], {(M+E){1'b1}}};
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = !w_fifo_full;
    assign fifo_count = w_fifo_count;
    assign div_start  = r_div_start;
    assign div_x      = r_div_x;
    assign div_d      = r_div_d;
    assign out_res    = r_out_res;
    assign out_valid  = r_out_valid;
    assign busy       = !w_fifo_empty || (r_state != IDLE) || r_out_valid;

endmodule

// File: tb/tb_fphub_div_sequencer.sv
// Bench for fphub_div_sequencer: stub divider with programmable latency,
// scoreboard of expected results in push order, scenario tasks.
module tb_fphub_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        div_finish = 1'b0;
    logic [31:0] in_x = 32'd0;
    logic [31:0] in_d = 32'd0;
    logic [31:0] div_res = 32'd0;
    logic        in_ready, out_valid, div_start, busy;
    logic [31:0] out_res, div_x, div_d;
    logic [2:0]  fifo_count;
`ifdef FPHUB_DIV_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_out = 0;
    int n_start = 0;
    bit saw_full = 1'b0;
    bit rr_en = 1'b0;

    // stub divider controls
    int          stub_target = -1;
    int          stub_lat = 3;
    bit          stub_rand = 1'b0;
    bit          stub_stale = 1'b0;
    bit          stub_force = 1'b0;
    logic [31:0] stub_force_val = 32'd0;
    logic [31:0] rec_x = 32'd0;
    logic [31:0] rec_d = 32'd0;

    logic [31:0] exp_q[$];

    fphub_div_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_d       (in_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .div_start  (div_start),
        .div_x      (div_x),
        .div_d      (div_d),
        .div_res    (div_res),
        .div_finish (div_finish),
        .fifo_count (fifo_count),
        .busy       (busy)
`ifdef FPHUB_DIV_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the quotient the stub divider returns for an operand pair.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] d);
        return x ^ {d[15:0], d[31:16]} ^ 32'h5A5A_0001;
    endfunction

    // Stub divider: answers stub_lat cycles after a start, optional stale finish in ISSUE.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            stub_target = -1;
            div_finish  = 1'b0;
        end else begin
            div_finish = 1'b0;
            if (stub_target >= 0) begin
                n_cmp++;
                if (div_x !== rec_x || div_d !== rec_d) begin
                    n_fail++;
                    $display("FAIL operand_hold: div_x=%h div_d=%h required %h %h", div_x, div_d, rec_x, rec_d);
                end
            end
            if (div_start) begin
                n_start++;
                rec_x = div_x;
                rec_d = div_d;
                stub_target = cyc + (stub_rand ? int'($urandom_range(1, 8)) : stub_lat);
                if (stub_stale) begin
                    div_finish = 1'b1;
                    div_res    = 32'hDEAD_BEEF;
                end
            end else if (stub_target >= 0 && cyc == stub_target) begin
                div_finish  = 1'b1;
                div_res     = stub_force ? stub_force_val : ref_div(rec_x, rec_d);
                stub_target = -1;
            end
        end
    end

    // Scoreboard and stream-level invariants.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(stub_force ? stub_force_val : ref_div(in_x, in_d));
            end
            if (fifo_count == 3'd4) saw_full = 1'b1;
            n_cmp++;
            if (in_ready !== (fifo_count != 3'd4) || fifo_count > 3'd4) begin
                n_fail++;
                $display("FAIL in_ready_vs_count: in_ready=%b fifo_count=%0d", in_ready, fifo_count);
            end
            if (out_valid && out_ready) begin
                n_out++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_order: got %h, required no result", out_res);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (out_res !== e) begin
                        n_fail++;
                        $display("FAIL result_order: got %h required %h", out_res, e);
                    end
                end
            end
        end
    end

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        if (rr_en) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [31:0] x, input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_x = x;
        in_d = d;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL push_accept: in_ready never 1 for x=%h", x);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            done = (exp_q.size() == 0) && !busy && (stub_target < 0);
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain: busy=%b pending=%0d after %0d cycles, required idle", busy, exp_q.size(), budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp += 8;
        if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL %s_out_valid: %b required 0", tag, out_valid); end
        if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL %s_in_ready: %b required 1", tag, in_ready); end
        if (fifo_count !== 3'd0)  begin n_fail++; $display("FAIL %s_fifo_count: %0d required 0", tag, fifo_count); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL %s_busy: %b required 0", tag, busy); end
        if (div_start !== 1'b0)   begin n_fail++; $display("FAIL %s_div_start: %b required 0", tag, div_start); end
        if (out_res !== 32'd0)    begin n_fail++; $display("FAIL %s_out_res: %h required 0", tag, out_res); end
        if (div_x !== 32'd0)      begin n_fail++; $display("FAIL %s_div_x: %h required 0", tag, div_x); end
        if (div_d !== 32'd0)      begin n_fail++; $display("FAIL %s_div_d: %h required 0", tag, div_d); end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        int c0, t_start, t_ov, s0;
        stub_force = 1'b1; stub_force_val = 32'h3F80_0000;
        stub_rand = 1'b0; stub_lat = 5; out_ready = 1'b0;
        c0 = cyc; s0 = n_start; t_start = -1; t_ov = -1;
        push_op(32'h4000_0000, 32'h4000_0000);
        for (int k = 0; k < 20 && t_ov < 0; k++) begin
            @(negedge clk);
            if (div_start && t_start < 0) t_start = cyc;
            if (out_valid) t_ov = cyc;
        end
        n_cmp += 4;
        if (t_start != c0 + 2) begin n_fail++; $display("FAIL single_start_cycle: %0d required %0d", t_start - c0, 2); end
        if (t_ov != c0 + 8)    begin n_fail++; $display("FAIL single_out_cycle: %0d required %0d", t_ov - c0, 8); end
        if (n_start - s0 != 1) begin n_fail++; $display("FAIL single_start_count: %0d required 1", n_start - s0); end
        if (out_res !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_res: %h required 3f800000", out_res); end
        repeat (3) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_res !== 32'h3F80_0000) begin
                n_fail++;
                $display("FAIL single_hold: valid=%b res=%h required 1 3f800000", out_valid, out_res);
            end
        end
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_after: busy=%b valid=%b required 0 0", busy, out_valid);
        end
        tick();
        stub_force = 1'b0;
    endtask

    task automatic test_back_to_back;
        int o0;
        stub_rand = 1'b0; stub_lat = 6; out_ready = 1'b1; saw_full = 1'b0;
        o0 = n_out;
        for (int i = 0; i < 4; i++) push_op($urandom, $urandom);
        wait_idle(200);
        stub_lat = 14;
        for (int i = 0; i < 7; i++) push_op($urandom, $urandom);
        wait_idle(400);
        n_cmp += 2;
        if (!saw_full) begin n_fail++; $display("FAIL fifo_full_seen: 0 required 1"); end
        if (n_out - o0 != 11) begin n_fail++; $display("FAIL b2b_count: %0d required 11", n_out - o0); end
    endtask

    task automatic test_random;
        int o0;
        o0 = n_out;
        stub_rand = 1'b1; rr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_op($urandom, $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        rr_en = 1'b0;
        tick();
        out_ready = 1'b1;
        wait_idle(600);
        stub_rand = 1'b0;
        n_cmp++;
        if (n_out - o0 != 16) begin n_fail++; $display("FAIL random_count: %0d required 16", n_out - o0); end
    endtask

    task automatic test_stale;
        int o0;
        o0 = n_out;
        stub_stale = 1'b1; stub_lat = 4; out_ready = 1'b1;
        push_op(32'h1234_5678, 32'h8765_4321);
        push_op(32'hCAFE_F00D, 32'h0BAD_CAFE);
        wait_idle(100);
        stub_stale = 1'b0;
        n_cmp++;
        if (n_out - o0 != 2) begin n_fail++; $display("FAIL stale_count: %0d required 2", n_out - o0); end
    endtask

    task automatic test_backpressure;
        logic [31:0] hold_res;
        int s0, h, t_next;
        stub_lat = 3; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_op($urandom, $urandom);
        for (int k = 0; k < 50 && !out_valid; k++) tick();
        hold_res = out_res;
        s0 = n_start;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_res !== hold_res) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%b res=%h required 1 %h", out_valid, out_res, hold_res);
            end
            tick();
        end
        n_cmp += 2;
        if (n_start != s0) begin n_fail++; $display("FAIL bp_no_issue: %0d starts required 0", n_start - s0); end
        if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL bp_queued: %0d required 3", fifo_count); end
        out_ready = 1'b1;
        h = cyc; t_next = -1;
        for (int k = 0; k < 10 && t_next < 0; k++) begin
            @(negedge clk);
            if (div_start) t_next = cyc;
            tick();
        end
        n_cmp++;
        if (t_next != h + 2) begin n_fail++; $display("FAIL bp_reissue: %0d cycles required 2", t_next - h); end
        wait_idle(200);
    endtask

    task automatic test_reset_mid;
        bit ok;
        stub_lat = 40; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_op($urandom, $urandom);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = (stub_target >= 0) && (fifo_count == 3'd2);
            if (!ok) tick();
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL mid_setup: fifo_count=%0d required 2 in WAIT", fifo_count); end
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || div_start !== 1'b0 || fifo_count !== 3'd0) begin
                n_fail++;
                $display("FAIL midrst_quiet: valid=%b start=%b count=%0d required 0 0 0", out_valid, div_start, fifo_count);
            end
        end
        tick();
        stub_lat = 3;
    endtask

`ifdef FPHUB_DIV_TIMEOUT_EN
    task automatic test_timeout;
        int t_s, t_e, pulses, t_n;
        stub_lat = 100000; stub_force = 1'b1; stub_force_val = 32'hFFFF_FFFF; out_ready = 1'b0;
        push_op(32'hC000_0000, 32'h4000_0000);
        push_op(32'hC000_0000, 32'h4000_0000);
        t_s = -1; t_e = -1; pulses = 0; t_n = -1;
        for (int k = 0; k < 150 && !out_valid; k++) begin
            @(negedge clk);
            if (div_start && t_s < 0) t_s = cyc;
            if (timeout_err) begin pulses++; if (t_e < 0) t_e = cyc; end
            tick();
        end
        @(negedge clk);
        if (timeout_err) pulses++;
        n_cmp += 3;
        if (t_e != t_s + 65) begin n_fail++; $display("FAIL to_cycle: %0d required 65", t_e - t_s); end
        if (pulses != 1)     begin n_fail++; $display("FAIL to_pulse: %0d required 1", pulses); end
        if (out_res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_res: %h required ffffffff", out_res); end
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 6 && t_n < 0; k++) begin
            @(negedge clk);
            if (div_start) t_n = cyc;
            tick();
        end
        n_cmp++;
        if (t_n < 0) begin n_fail++; $display("FAIL to_next_issue: none required 1"); end
        #2 rst = 1'b1;
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        tick();
        stub_force = 1'b0; stub_lat = 3;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stale();
        test_backpressure();
        test_random();
`ifdef FPHUB_DIV_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
